// File: rtl/bc1_decode_scheduler.sv
// ---------------------------------------------------------------------------
// bc1_decode_scheduler
//
// Shares a single BC1 block decoder between NUM_REQ texture-cache/TMU
// requesters. A round-robin arbiter picks one requester at a time. The
// scheduler hands that requester's 64-bit block to the decoder. It then
// watches the 16-texel stream coming back and forwards each texel,
// registered and tagged, to the requester that owns it. Only one block is
// in flight at any time, so the arbiter stays idle until the current block
// finishes or times out.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester request, one-hot accept
//   req_block / req_tag        flattened blocks (64b each) and tags (TAG_W each)
//   dec_valid / dec_ready      block handoff to the decoder
//   dec_block                  block presented to the decoder
//   dec_pix_valid              decoder texel beat
//   dec_pix_index, dec_rgb,    texel index, RGB888 colour and transparent
//   dec_alpha                  flag from the decoder
//   out_valid                  registered texel output
//   out_id, out_tag            owning requester and its tag
//   out_index, out_rgb,        forwarded texel fields
//   out_alpha
//   out_last                   high with the 16th texel of a block
//   busy                       scheduler not idle
//   err_timeout                one-cycle pulse when a stream is abandoned
//   err_seq                    sticky flag for an out-of-order texel index
// ---------------------------------------------------------------------------
module bc1_decode_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*64-1:0]      req_block,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       dec_valid,
    output logic [63:0]                dec_block,
    input  logic                       dec_ready,
    input  logic                       dec_pix_valid,
    input  logic [3:0]                 dec_pix_index,
    input  logic [23:0]                dec_rgb,
    input  logic                       dec_alpha,
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_index,
    output logic [23:0]                out_rgb,
    output logic                       out_alpha,
    output logic                       out_last,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       err_seq
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  IDLE_MAX = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     rr_ptr_d;
    logic [IDW-1:0]     id_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        blk_q;
    logic               dec_valid_q;
    logic [3:0]         beat_cnt_q;
    logic [CW-1:0]      idle_cnt_q;
    logic               out_valid_q;
    logic [IDW-1:0]     out_id_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [3:0]         out_index_q;
    logic [23:0]        out_rgb_q;
    logic               out_alpha_q;
    logic               out_last_q;
    logic               err_timeout_q;
    logic               err_seq_q;

    logic [63:0]        blk_arr [NUM_REQ];
    logic [TAG_W-1:0]   tag_arr [NUM_REQ];
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic               grant_fire;

    // First requesting port at or after ptr, wrapping; result is {found, index}.
    function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] v,
                                          input logic [IDW-1:0]     ptr);
        logic           found;
        logic [IDW-1:0] sel;
        logic [IDW-1:0] cand;
        int             idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            cand = IDW'(idx);
            if (!found && v[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            blk_arr[i] = req_block[i*64 +: 64];
            tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
        end
    end

    always_comb begin
        {grant_vld, grant_idx} = pick(req_valid, rr_ptr_q);
    end

    // A grant only happens from IDLE when the decoder can take the block
    // right away, so the accepted block goes straight into the ISSUE register.
    assign grant_fire = (state_q == IDLE) && dec_ready && grant_vld;

    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Priority moves to the port after the one just served, whether the
    // block completed or was abandoned.
    assign rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            tag_q         <= '0;
            blk_q         <= '0;
            dec_valid_q   <= 1'b0;
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_id_q      <= '0;
            out_tag_q     <= '0;
            out_index_q   <= '0;
            out_rgb_q     <= '0;
            out_alpha_q   <= 1'b0;
            out_last_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        blk_q       <= blk_arr[grant_idx];
                        tag_q       <= tag_arr[grant_idx];
                        id_q        <= grant_idx;
                        dec_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dec_ready) begin
                        dec_valid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        idle_cnt_q  <= '0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (dec_pix_valid) begin
                        // A mis-ordered texel is flagged but still forwarded.
                        out_valid_q <= 1'b1;
                        out_id_q    <= id_q;
                        out_tag_q   <= tag_q;
                        out_index_q <= dec_pix_index;
                        out_rgb_q   <= dec_rgb;
                        out_alpha_q <= dec_alpha;
                        idle_cnt_q  <= '0;
                        beat_cnt_q  <= beat_cnt_q + 4'd1;
                        if (dec_pix_index != beat_cnt_q) begin
                            err_seq_q <= 1'b1;
                        end
                        if (beat_cnt_q == 4'd15) begin
                            out_last_q <= 1'b1;
                            rr_ptr_q   <= rr_ptr_d;
                            state_q    <= IDLE;
                        end
                    end else if (idle_cnt_q == IDLE_MAX) begin
                        err_timeout_q <= 1'b1;
                        rr_ptr_q      <= rr_ptr_d;
                        state_q       <= IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dec_valid   = dec_valid_q;
    assign dec_block   = blk_q;
    assign out_valid   = out_valid_q;
    assign out_id      = out_id_q;
    assign out_tag     = out_tag_q;
    assign out_index   = out_index_q;
    assign out_rgb     = out_rgb_q;
    assign out_alpha   = out_alpha_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_timeout_q;
    assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_bc1_decode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bc1_decode_scheduler
//
// Directed bench for the BC1 decode scheduler. The bench drives inputs one
// time unit after each rising clock edge and samples outputs in the same
// slot. A table of decoder beats, each paired with its expected texel
// outputs, drives the single-requester and mis-ordered-index cases. Short
// hand-written sequences cover mid-stream reset, arbitration order, decoder
// backpressure and stream timeout.
// ---------------------------------------------------------------------------
module tb_bc1_decode_scheduler;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   reqValid;
    logic [3:0]   reqReady;
    logic [255:0] reqBlock;
    logic [31:0]  reqTag;
    logic         decValid;
    logic [63:0]  decBlock;
    logic         decReady;
    logic         decPixValid;
    logic [3:0]   decPixIndex;
    logic [23:0]  decRgb;
    logic         decAlpha;
    logic         outValid;
    logic [1:0]   outId;
    logic [7:0]   outTag;
    logic [3:0]   outIndex;
    logic [23:0]  outRgb;
    logic         outAlpha;
    logic         outLast;
    logic         busy;
    logic         errTimeout;
    logic         errSeq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pixValid;
        logic [3:0]  pixIndex;
        logic [23:0] rgb;
        logic        alpha;
        logic        expValid;
        logic [3:0]  expIndex;
        logic [23:0] expRgb;
        logic        expAlpha;
        logic        expLast;
        logic        expBusy;
        logic        expErrSeq;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bc1_decode_scheduler #(
        .NUM_REQ (4),
        .TAG_W   (8),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (reqValid),
        .req_ready     (reqReady),
        .req_block     (reqBlock),
        .req_tag       (reqTag),
        .dec_valid     (decValid),
        .dec_block     (decBlock),
        .dec_ready     (decReady),
        .dec_pix_valid (decPixValid),
        .dec_pix_index (decPixIndex),
        .dec_rgb       (decRgb),
        .dec_alpha     (decAlpha),
        .out_valid     (outValid),
        .out_id        (outId),
        .out_tag       (outTag),
        .out_index     (outIndex),
        .out_rgb       (outRgb),
        .out_alpha     (outAlpha),
        .out_last      (outLast),
        .busy          (busy),
        .err_timeout   (errTimeout),
        .err_seq       (errSeq)
    );

    // Compare one observed value against the value the bench expects.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one decoder beat from a table row.
    task automatic applyStimulus(input vec_t v);
        decPixValid = v.pixValid;
        decPixIndex = v.pixIndex;
        decRgb      = v.rgb;
        decAlpha    = v.alpha;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] beatRgb(input int b);
        return {8'(b * 17), 8'(8'hF0 ^ b), 8'(b + 3)};
    endfunction

    // Never more than one accept bit, and never an accept while busy.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            checks++;
            if (!$onehot0(reqReady) || (busy && reqReady != 4'b0)) begin
                errors++;
                $display("[TB] FAIL ready_onehot_idle: got req_ready=%b busy=%b, expected onehot0 and idle", reqReady, busy);
            end
        end
    end

    task automatic doReset();
        rstn        = 1'b0;
        reqValid    = '0;
        decReady    = 1'b0;
        decPixValid = 1'b0;
        decPixIndex = '0;
        decRgb      = '0;
        decAlpha    = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
    endtask

    // Request from one port, confirm the immediate grant and the decoder handoff.
    task automatic issueBlock(input int port, input logic [7:0] tag, input logic [63:0] blk,
                              input logic [3:0] alsoValid);
        int waitCnt;
        reqBlock[port*64 +: 64] = blk;
        reqTag[port*8 +: 8]     = tag;
        reqValid                = alsoValid | (4'b1 << port);
        decReady                = 1'b1;
        #1;
        waitCnt = 0;
        while (reqReady == 4'b0 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput($sformatf("grant_p%0d", port), reqReady, 64'(4'b1 << port));
        checkOutput("grant_wait", waitCnt, 0);
        tick();
        reqValid = alsoValid;
        checkOutput("dec_valid_set", decValid, 1);
        checkOutput("dec_block", decBlock, blk);
        checkOutput("busy_issue", busy, 1);
        tick();
        checkOutput("dec_valid_drop", decValid, 0);
    endtask

    // Feed n in-order beats and check each forwarded texel.
    task automatic streamClean(input int n, input int expId, input logic [7:0] expTag);
        for (int b = 0; b < n; b++) begin
            decPixValid = 1'b1;
            decPixIndex = 4'(b);
            decRgb      = beatRgb(b);
            decAlpha    = 1'(b & 1);
            tick();
            checkOutput($sformatf("beat%0d_valid", b), outValid, 1);
            checkOutput($sformatf("beat%0d_index", b), outIndex, 64'(b));
            checkOutput($sformatf("beat%0d_id", b), outId, 64'(expId));
            checkOutput($sformatf("beat%0d_tag", b), outTag, expTag);
            checkOutput($sformatf("beat%0d_last", b), outLast, 64'(b == 15));
        end
        decPixValid = 1'b0;
    endtask

    // mode 0: in-order beats with one idle gap; mode 1: index order 0,1,3,4,..,15,2.
    task automatic fillTable(input int mode);
        vec_t v;
        int   idx;
        vecs.delete();
        for (int b = 0; b < 16; b++) begin
            if (mode == 0 && b == 5) begin
                v = '{1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b0};
                vecs.push_back(v);
            end
            idx = (mode == 0) ? b : ((b < 2) ? b : ((b == 15) ? 2 : b + 1));
            v = '{1'b1, 4'(idx), beatRgb(b), 1'(b & 1),
                  1'b1, 4'(idx), beatRgb(b), 1'(b & 1),
                  (b == 15), (b != 15), (mode == 1 && b >= 2)};
            vecs.push_back(v);
        end
        v = '{1'b1, 4'd0, 24'h123456, 1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 1'b0, (mode == 1)};
        vecs.push_back(v);
    endtask

    task automatic runTable(input int expId, input logic [7:0] expTag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("row%0d_valid", i), outValid, vecs[i].expValid);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("row%0d_index", i), outIndex, vecs[i].expIndex);
                checkOutput($sformatf("row%0d_rgb", i), outRgb, vecs[i].expRgb);
                checkOutput($sformatf("row%0d_alpha", i), outAlpha, vecs[i].expAlpha);
                checkOutput($sformatf("row%0d_id", i), outId, 64'(expId));
                checkOutput($sformatf("row%0d_tag", i), outTag, expTag);
            end
            checkOutput($sformatf("row%0d_last", i), outLast, vecs[i].expLast);
            checkOutput($sformatf("row%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("row%0d_err_seq", i), errSeq, vecs[i].expErrSeq);
        end
        decPixValid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int order[5];
        int pulses;
        int pulseAt;
        int lastSeen;

        reqBlock = '0;
        reqTag   = '0;
        order    = '{0, 1, 2, 3, 0};

        // Reset values
        doReset();
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_last", outLast, 0);
        checkOutput("rst_dec_valid", decValid, 0);
        checkOutput("rst_err_timeout", errTimeout, 0);
        checkOutput("rst_err_seq", errSeq, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_rgb", outRgb, 0);
        checkOutput("rst_out_tag", outTag, 0);
        checkOutput("rst_req_ready", reqReady, 0);

        // Single requester on port 2, table-driven stream
        $display("[TB] single request port 2");
        issueBlock(2, 8'h5A, 64'hF800_001F_E4E4_E4E4, 4'b0);
        fillTable(0);
        runTable(2, 8'h5A);

        // Reset in the middle of a stream
        $display("[TB] reset mid-stream");
        doReset();
        issueBlock(0, 8'h01, 64'h1111_2222_3333_4444, 4'b0);
        streamClean(16, 0, 8'h01);
        issueBlock(2, 8'h02, 64'h5555_6666_7777_8888, 4'b0);
        streamClean(8, 2, 8'h02);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_last", outLast, 0);
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        issueBlock(0, 8'h03, 64'h9999_AAAA_BBBB_CCCC, 4'b0100);

        // All ports requesting continuously: strict rotation
        $display("[TB] round robin");
        doReset();
        for (int g = 0; g < 5; g++) begin
            issueBlock(order[g], 8'(8'h30 + g), 64'hA5A5_0000_0000_0000 | 64'(g), 4'hF);
            streamClean(16, order[g], 8'(8'h30 + g));
        end

        // Decoder not ready: no accept until it is
        $display("[TB] decoder backpressure");
        doReset();
        reqValid = 4'b0010;
        decReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp%0d_req_ready", c), reqReady, 0);
            tick();
            checkOutput($sformatf("bp%0d_busy", c), busy, 0);
        end
        issueBlock(1, 8'h11, 64'hDEAD_BEEF_0123_4567, 4'b0);
        streamClean(16, 1, 8'h11);

        // Stall after four beats until the stream is abandoned
        $display("[TB] stream timeout");
        doReset();
        issueBlock(0, 8'h22, 64'h0F0F_F0F0_0F0F_F0F0, 4'b0);
        streamClean(4, 0, 8'h22);
        reqValid = 4'b0011;
        decReady = 1'b0;
        pulses   = 0;
        pulseAt  = 0;
        lastSeen = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (errTimeout) begin
                pulses++;
                pulseAt = k;
            end
            if (outLast) lastSeen++;
        end
        checkOutput("to_pulses", pulses, 1);
        checkOutput("to_pulse_cycle", pulseAt, 64);
        checkOutput("to_no_last", lastSeen, 0);
        checkOutput("to_busy", busy, 0);
        decReady = 1'b1;
        #1;
        checkOutput("to_next_grant", reqReady, 4'b0010);

        // Out-of-order index: sticky error, texels still forwarded
        $display("[TB] index sequence error");
        doReset();
        issueBlock(3, 8'hC3, 64'h0123_4567_89AB_CDEF, 4'b0);
        fillTable(1);
        runTable(3, 8'hC3);
        tick();
        checkOutput("seq_sticky", errSeq, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
